// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage registers.
//   stage_state_e : occupancy state of a pipe_stage_buf
//   NOP_INST      : addi x0,x0,0, used as the bubble instruction
//   *_t           : per-stage payload layouts
//   occ_of_state  : number of entries held in a given state
package pipe_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } stage_state_e;

   localparam logic [31:0] NOP_INST = 32'h0000_0013;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] inst;
   } if_id_t;

   typedef struct packed {
      logic [63:0] pc;
      logic [63:0] rs1_val;
      logic [63:0] rs2_val;
      logic [31:0] inst;
   } id_ex_t;

   function automatic logic [1:0] occ_of_state(input stage_state_e st);
      logic [1:0] occ;
      occ = 2'd0;
      case (st)
         ST_FULL: occ = 2'd1;
         ST_SKID: occ = 2'd2;
         default: occ = 2'd0;
      endcase
      return occ;
   endfunction

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
//   clk   : clock
//   rst   : synchronous clear
//   inc_i : count this cycle
//   cnt_o : current count, sticks at all-ones
module pipe_sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc_i,
   output logic [WIDTH-1:0] cnt_o
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer
// and synchronous flush. in_ready is registered, so there is no
// combinational path from out_ready to in_ready.
// Optional macro PIPE_STAGE_PERF_CNT_EN adds stall_cnt / flush_cnt.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : upstream handshake, in_data payload
//   out_valid/out_ready : downstream handshake, out_data payload
//                         (BUBBLE_VAL when nothing is held)
//   flush               : discard all held entries
//   occupancy           : entries held, 0..2
//
// state    | meaning
// ST_EMPTY | main invalid, skid invalid
// ST_FULL  | main valid,   skid invalid
// ST_SKID  | main valid,   skid valid, in_ready low
module pipe_stage_buf
   import pipe_pkg::*;
#(
   parameter int                    DATA_WIDTH = 96,
   parameter logic [DATA_WIDTH-1:0] BUBBLE_VAL = {{(DATA_WIDTH-32){1'b0}}, NOP_INST},
   parameter int                    CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   input  logic                  flush,
   output logic [1:0]            occupancy
`ifdef PIPE_STAGE_PERF_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0]  stall_cnt,
   output logic [CNT_WIDTH-1:0]  flush_cnt
`endif
);

   stage_state_e          state_q, state_d;
   logic [DATA_WIDTH-1:0] main_q, main_d;
   logic [DATA_WIDTH-1:0] skid_q, skid_d;
   logic                  in_ready_q, in_ready_d;
   logic                  in_fire, out_fire;

   assign in_fire  = in_valid & in_ready_q;
   assign out_fire = out_valid & out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         ST_EMPTY: begin
            if (in_fire) begin
               state_d = ST_FULL;
               main_d  = in_data;
            end
         end
         ST_FULL: begin
            if (in_fire && out_fire) begin
               main_d = in_data;
            end else if (in_fire) begin
               state_d = ST_SKID;
               skid_d  = in_data;
            end else if (out_fire) begin
               state_d = ST_EMPTY;
            end
         end
         ST_SKID: begin
            if (out_fire) begin
               state_d = ST_FULL;
               main_d  = skid_q;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      // Flush wins: any same-cycle in_fire is dropped, any out_fire has
      // already completed downstream.
      if (flush) begin
         state_d = ST_EMPTY;
      end
      in_ready_d = (state_d != ST_SKID);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_EMPTY;
         in_ready_q <= 1'b1;
         main_q     <= '0;
         skid_q     <= '0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
         main_q     <= main_d;
         skid_q     <= skid_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q != ST_EMPTY);
   assign out_data  = out_valid ? main_q : BUBBLE_VAL;
   assign occupancy = occ_of_state(state_q);

`ifdef PIPE_STAGE_PERF_CNT_EN
   logic stall_inc, flush_inc;

   assign stall_inc = out_valid & ~out_ready;
   assign flush_inc = flush & (state_q != ST_EMPTY);

   pipe_sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (stall_inc),
      .cnt_o (stall_cnt)
   );

   pipe_sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc_i (flush_inc),
      .cnt_o (flush_cnt)
   );
`else
   localparam int unused_cnt_width = CNT_WIDTH;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;
   localparam int          DW  = 96;
   localparam logic [95:0] BUB = 96'h0000_0000_0000_0000_0000_0013;

   logic          clk = 1'b0;
   logic          rst, in_valid, out_ready, flush;
   logic [DW-1:0] in_data;
   logic          in_ready, out_valid;
   logic [DW-1:0] out_data;
   logic [1:0]    occupancy;

   always #5 clk = ~clk;

`ifdef PIPE_STAGE_PERF_CNT_EN
   logic [31:0] stall_cnt, flush_cnt;
   logic        in_ready4, out_valid4;
   logic [DW-1:0] out_data4;
   logic [1:0]  occupancy4;
   logic [3:0]  stall_cnt4, flush_cnt4;
`endif

   pipe_stage_buf #(.DATA_WIDTH(DW), .BUBBLE_VAL(BUB), .CNT_WIDTH(32)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .flush     (flush),
      .occupancy (occupancy)
`ifdef PIPE_STAGE_PERF_CNT_EN
      ,
      .stall_cnt (stall_cnt),
      .flush_cnt (flush_cnt)
`endif
   );

`ifdef PIPE_STAGE_PERF_CNT_EN
   pipe_stage_buf #(.DATA_WIDTH(DW), .BUBBLE_VAL(BUB), .CNT_WIDTH(4)) u_dut4 (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready4),
      .in_data   (in_data),
      .out_valid (out_valid4),
      .out_ready (out_ready),
      .out_data  (out_data4),
      .flush     (flush),
      .occupancy (occupancy4),
      .stall_cnt (stall_cnt4),
      .flush_cnt (flush_cnt4)
   );
`endif

   int n_pass  = 0;
   int n_total = 0;

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   // Reference model: a FIFO of at most two held payloads.
   logic [DW-1:0] mq[$];
   bit            m_ready = 1'b1;
   longint        m_stall = 0;
   longint        m_flush = 0;
   localparam longint MAX32 = 64'h0000_0000_FFFF_FFFF;

   always @(posedge clk) begin
      bit inf, outf;
      inf  = in_valid && m_ready;
      outf = (mq.size() != 0) && out_ready;
      if (rst) begin
         mq.delete();
         m_ready = 1'b1;
         m_stall = 0;
         m_flush = 0;
      end else begin
         if (mq.size() != 0 && !out_ready && m_stall < MAX32) m_stall++;
         if (flush && mq.size() != 0 && m_flush < MAX32) m_flush++;
         if (flush) mq.delete();
         else begin
            if (outf) void'(mq.pop_front());
            if (inf)  mq.push_back(in_data);
         end
         m_ready = (mq.size() < 2);
      end
   end

   bit chk_en = 1'b0;

   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_out_valid", {95'd0, out_valid}, {95'd0, mq.size() != 0});
         chk("m_in_ready",  {95'd0, in_ready},  {95'd0, m_ready});
         chk("m_occupancy", {94'd0, occupancy}, 96'(mq.size()));
         chk("m_out_data",  out_data, (mq.size() != 0) ? mq[0] : BUB);
`ifdef PIPE_STAGE_PERF_CNT_EN
         chk("m_stall_cnt", {64'd0, stall_cnt}, 96'(m_stall));
         chk("m_flush_cnt", {64'd0, flush_cnt}, 96'(m_flush));
         chk("m_stall_cnt4", {92'd0, stall_cnt4}, 96'((m_stall > 15) ? 15 : m_stall));
`endif
      end
   end

   task automatic cyc(input logic r, input logic iv, input logic [DW-1:0] d,
                      input logic ordy, input logic fl);
      rst = r; in_valid = iv; in_data = d; out_ready = ordy; flush = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string name, input logic v, input logic [DW-1:0] d,
                             input logic [1:0] occ, input logic rdy);
      chk({name, "_valid"}, {95'd0, out_valid}, {95'd0, v});
      chk({name, "_data"},  out_data, d);
      chk({name, "_occ"},   {94'd0, occupancy}, {94'd0, occ});
      chk({name, "_ready"}, {95'd0, in_ready}, {95'd0, rdy});
   endtask

   localparam logic [95:0] P0 = 96'h0000_0000_8000_0000_0000_0013;
   localparam logic [95:0] P1 = 96'h0000_0000_8000_0004_0010_0093;
   localparam logic [95:0] PA = 96'hAAAA_0000_0000_0000_0000_000A;
   localparam logic [95:0] PB = 96'hBBBB_0000_0000_0000_0000_000B;
   localparam logic [95:0] PC = 96'hCCCC_0000_0000_0000_0000_000C;
   localparam logic [95:0] PD = 96'hDDDD_0000_0000_0000_0000_000D;
   localparam logic [95:0] PE = 96'hEEEE_0000_0000_0000_0000_000E;

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0; flush = 1'b0;
      cyc(1, 0, '0, 0, 0);
      cyc(1, 0, '0, 0, 0);
      chk_en = 1'b1;
      expect_out("reset", 0, BUB, 2'd0, 1);

      // streaming
      cyc(0, 1, P0, 1, 0);
      expect_out("stream0", 1, P0, 2'd1, 1);
      cyc(0, 1, P1, 1, 0);
      expect_out("stream1", 1, P1, 2'd1, 1);
      cyc(0, 0, '0, 1, 0);
      expect_out("stream_end", 0, BUB, 2'd0, 1);

      // backpressure, C waits upstream while in_ready is low
      cyc(0, 1, PA, 0, 0);
      expect_out("bp_a", 1, PA, 2'd1, 1);
      cyc(0, 1, PB, 0, 0);
      expect_out("bp_b", 1, PA, 2'd2, 0);
      cyc(0, 1, PC, 0, 0);
      expect_out("bp_hold", 1, PA, 2'd2, 0);
      cyc(0, 1, PC, 1, 0);
      expect_out("bp_drain_b", 1, PB, 2'd1, 1);
      cyc(0, 1, PC, 1, 0);
      expect_out("bp_drain_c", 1, PC, 2'd1, 1);
      cyc(0, 0, '0, 1, 0);
      expect_out("bp_empty", 0, BUB, 2'd0, 1);

      // flush while in SKID, D offered
      cyc(0, 1, PA, 0, 0);
      cyc(0, 1, PB, 0, 0);
      cyc(0, 1, PD, 0, 1);
      expect_out("flush_skid", 0, BUB, 2'd0, 1);
      // flush while FULL with a real in_fire of D: D dropped
      cyc(0, 1, PA, 0, 0);
      cyc(0, 1, PD, 0, 1);
      expect_out("flush_full", 0, BUB, 2'd0, 1);
      cyc(0, 0, '0, 1, 0);
      expect_out("flush_no_d", 0, BUB, 2'd0, 1);

      // reset in SKID, then E streams through
      cyc(0, 1, PA, 0, 0);
      cyc(0, 1, PB, 0, 0);
      cyc(1, 0, '0, 0, 0);
      expect_out("rst_mid", 0, BUB, 2'd0, 1);
      cyc(0, 1, PE, 1, 0);
      expect_out("rst_e", 1, PE, 2'd1, 1);
      cyc(0, 0, '0, 1, 0);

`ifdef PIPE_STAGE_PERF_CNT_EN
      cyc(1, 0, '0, 0, 0);
      cyc(0, 1, PA, 0, 0);
      for (int i = 0; i < 5; i++) cyc(0, 0, '0, 0, 0);
      cyc(0, 0, '0, 1, 1);
      chk("perf_stall5", {64'd0, stall_cnt}, 96'd5);
      chk("perf_flush1", {64'd0, flush_cnt}, 96'd1);
      cyc(0, 1, PA, 0, 0);
      for (int i = 0; i < 20; i++) cyc(0, 0, '0, 0, 0);
      chk("perf_stall25", {64'd0, stall_cnt}, 96'd25);
      chk("perf_sat4", {92'd0, stall_cnt4}, 96'd15);
      cyc(0, 0, '0, 1, 1);
`endif

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom_range(99) == 0), ($urandom_range(9) < 7),
             {$urandom, $urandom, $urandom},
             ($urandom_range(9) < 6), ($urandom_range(19) == 0));
      end

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
